// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter that owns a shared 2-to-4 one-hot select decoder for four requesters.
// Optional hold-time limit with forced release is enabled by defining LOCK_TIMEOUT_EN.
module decoder_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic [3:0] grant_q, grant_d;
    logic       timeout_q, timeout_d;

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] win_off;
    logic [1:0] win_idx;
    logic       hold_expired;

    function automatic logic [3:0] decode(input logic [1:0] idx, input logic en);
        decode = en ? (4'b0001 << idx) : 4'b0000;
    endfunction

    // Rotate req so bit 0 is the current highest-priority index, then pick the first set bit.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[{1'b0, ptr_q} +: 4];

    always_comb begin
        win_off = 2'd3;
        if (req_rot[0]) begin
            win_off = 2'd0;
        end else if (req_rot[1]) begin
            win_off = 2'd1;
        end else if (req_rot[2]) begin
            win_off = 2'd2;
        end
    end

    assign win_idx = ptr_q + win_off;

`ifdef LOCK_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    logic [7:0] hold_q, hold_d;

    // Counter is zero outside GRANT, so it is already clear on every entry to GRANT.
    always_comb begin
        hold_d = 8'd0;
        if (state_q == ST_GRANT) begin
            hold_d = hold_q + 8'd1;
        end
    end

    assign hold_expired = (state_q == ST_GRANT) && ((hold_q + 8'd1) == HOLD_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    logic unused_max_hold;

    assign unused_max_hold = (MAX_HOLD != 0);
    assign hold_expired    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_RELEASE: begin
                if (|req) begin
                    state_d = ST_GRANT;
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!req[idx_q] || hold_expired) begin
                    state_d   = ST_RELEASE;
                    valid_d   = 1'b0;
                    ptr_d     = idx_q + 2'd1;
                    // A voluntary drop in the same cycle wins over the timeout.
                    timeout_d = req[idx_q] && hold_expired;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
        grant_d = decode(idx_d, valid_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            idx_q     <= 2'd0;
            valid_q   <= 1'b0;
            grant_q   <= 4'b0000;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed table-driven bench for decoder_rr_arbiter, plus hand sequences for long holds
// and (with LOCK_TIMEOUT_EN) the forced-release path at MAX_HOLD=4.
module tb_decoder_rr_arbiter;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
    } vec_t;

    localparam int NV = 34;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    decoder_rr_arbiter #(
        .MAX_HOLD(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    // Drive inputs on the falling edge, let one rising edge sample them, check on the next fall.
    task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] eg,
                        input logic [1:0] ei, input logic ev, input logic et, input string name);
        reset = rst;
        req   = r;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({grant, grant_idx, grant_valid, timeout} !== {eg, ei, ev, et}) begin
            bad++;
            $display("FAIL %s: got grant=%b idx=%0d valid=%b timeout=%b, want grant=%b idx=%0d valid=%b timeout=%b",
                     name, grant, grant_idx, grant_valid, timeout, eg, ei, ev, et);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b1111;

        //            rst   req      grant    idx   valid
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};  // reset with all requesting
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};  // first grant after reset
        vecs[3]  = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
        vecs[4]  = '{1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0};
        vecs[5]  = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1};  // old owner back but lowest priority
        vecs[6]  = '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1};
        vecs[7]  = '{1'b0, 4'b1101, 4'b0000, 2'd1, 1'b0};
        vecs[8]  = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1};
        vecs[9]  = '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1};
        vecs[10] = '{1'b0, 4'b1011, 4'b0000, 2'd2, 1'b0};
        vecs[11] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1};
        vecs[12] = '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1};
        vecs[13] = '{1'b0, 4'b0111, 4'b0000, 2'd3, 1'b0};
        vecs[14] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};  // rotation wraps back to 0
        vecs[15] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
        vecs[16] = '{1'b0, 4'b1110, 4'b0000, 2'd0, 1'b0};
        vecs[17] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};  // release -> idle, idx retained
        vecs[18] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[19] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[20] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[21] = '{1'b0, 4'b1010, 4'b1000, 2'd3, 1'b1};  // late request, no preemption
        vecs[22] = '{1'b0, 4'b0011, 4'b0000, 2'd3, 1'b0};  // owner 3 releases, ptr wraps
        vecs[23] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1};
        vecs[24] = '{1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0};
        vecs[25] = '{1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1};
        vecs[26] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0};
        vecs[27] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0};
        vecs[28] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[29] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vecs[30] = '{1'b1, 4'b0101, 4'b0000, 2'd0, 1'b0};  // reset mid-GRANT
        vecs[31] = '{1'b0, 4'b0101, 4'b0001, 2'd0, 1'b1};  // ptr back at 0 after reset
        vecs[32] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[33] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].grant, vecs[i].idx, vecs[i].valid, 1'b0,
                 $sformatf("vec%0d", i));
        end

`ifndef LOCK_TIMEOUT_EN
        // Single requester held 5 cycles; ptr is 1 here so index 2 wins outright.
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, $sformatf("single_hold%0d", k));
        end
        step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "single_release");
        step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "single_idle");
        // Without the timeout feature ownership is unbounded.
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, $sformatf("long_hold%0d", k));
        end
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "long_release");
`else
        step(1'b1, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b0, "to_reset");
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, $sformatf("to_own0_%0d", k));
        end
        step(1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1, "to_forced");
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0, $sformatf("to_own1_%0d", k));
        end
        step(1'b0, 4'b0001, 4'b0000, 2'd1, 1'b0, 1'b0, "to_normal_release");
        step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "to_regrant");
        step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "to_final_release");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
